mcp3008_spi_responder: RTL and testbench

//  Synthesizable SPI target emulating an MCP3008 10-bit ADC (SPI mode 0,0), the responder end of our ADC SPI link.

---
 rtl/mcp3008_spi_responder.sv | 172 +++++++++++++++++
 tb/tb_mcp3008_spi_responder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mcp3008_spi_responder.sv
// MCP3008-style SPI target (mode 0,0): decodes the start, SGL/DIFF and D2..D0 bits, then shifts a null bit and B9..B0 out on MISO.
// Latency: each SCLK/CS edge takes effect SYNC_STAGES+1 clk later; conv_data is captured on the clk after the conv_req pulse.
// Backpressure: none. The SPI controller sets the pace, and the local source must present conv_data on the cycle after conv_req.
//
// Ports:
//   clk, rst_n                  system clock, asynchronous active-low reset
//   spi_cs_n, spi_clk, spi_mosi asynchronous SPI inputs from the controller
//   spi_miso, spi_miso_oe       response bit and pad enable (enable is high while selected)
//   conv_req                    one-clk request for a sample
//   conv_channel, conv_single   last decoded command
//   conv_data                   sample from the local source
//   xfer_done                   one-clk pulse when B0 has been driven
module mcp3008_spi_responder #(
    parameter int ADC_BITS    = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                spi_cs_n,
    input  logic                spi_clk,
    input  logic                spi_mosi,
    output logic                spi_miso,
    output logic                spi_miso_oe,
    output logic                conv_req,
    output logic [2:0]          conv_channel,
    output logic                conv_single,
    input  logic [ADC_BITS-1:0] conv_data,
    output logic                xfer_done
);

    localparam int CW = $clog2(ADC_BITS + 2);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        CONFIG,
        SAMPLE,
        CAPTURE,
        SHIFT,
        TAIL
    } state_t;

    state_t              state;
    logic [CW-1:0]       bitcnt;
    logic [ADC_BITS-1:0] shreg;

    // The synchronizers reset to the bus idle levels, so leaving reset does not
    // fabricate an SCLK or CS edge.
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_q;
    logic                   cs_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_q    <= 1'b0;
            cs_q      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sclk_q    <= sclk_sync[SYNC_STAGES-1];
            cs_q      <= cs_sync[SYNC_STAGES-1];
        end
    end

    logic sclk_s, cs_s, mosi_s;
    logic rise, fall, cs_rise, cs_fall;

    assign sclk_s  = sclk_sync[SYNC_STAGES-1];
    assign cs_s    = cs_sync[SYNC_STAGES-1];
    // MOSI goes through the same number of stages as SCLK, so it stays aligned with the rise strobe.
    assign mosi_s  = mosi_sync[SYNC_STAGES-1];
    assign rise    = sclk_s & ~sclk_q;
    assign fall    = ~sclk_s & sclk_q;
    assign cs_rise = cs_s & ~cs_q;
    assign cs_fall = ~cs_s & cs_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            bitcnt       <= '0;
            shreg        <= '0;
            spi_miso     <= 1'b0;
            spi_miso_oe  <= 1'b0;
            conv_req     <= 1'b0;
            conv_channel <= 3'd0;
            conv_single  <= 1'b0;
            xfer_done    <= 1'b0;
        end else begin
            conv_req  <= 1'b0;
            xfer_done <= 1'b0;
            if (cs_rise) begin
                // Deselect aborts from any state. This takes priority over an SCLK
                // edge in the same cycle. The decoded command is kept.
                state       <= IDLE;
                spi_miso    <= 1'b0;
                spi_miso_oe <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        spi_miso <= 1'b0;
                        if (cs_fall) begin
                            state       <= WAIT_START;
                            spi_miso_oe <= 1'b1;
                        end
                    end
                    WAIT_START: begin
                        if (rise && mosi_s) begin
                            state  <= CONFIG;
                            bitcnt <= '0;
                        end
                    end
                    CONFIG: begin
                        if (rise) begin
                            // The first bit is SGL/DIFF. The next three shift in as D2..D0.
                            if (bitcnt == '0) begin
                                conv_single <= mosi_s;
                            end else begin
                                conv_channel <= {conv_channel[1:0], mosi_s};
                            end
                            bitcnt <= bitcnt + CW'(1);
                            if (bitcnt == CW'(3)) begin
                                state <= SAMPLE;
                            end
                        end
                    end
                    SAMPLE: begin
                        if (rise) begin
                            conv_req <= 1'b1;
                            state    <= CAPTURE;
                        end
                    end
                    CAPTURE: begin
                        shreg  <= conv_data;
                        bitcnt <= '0;
                        state  <= SHIFT;
                    end
                    SHIFT: begin
                        if (fall) begin
                            // Count 0 is the null bit. Counts 1..ADC_BITS shift out the data MSB first.
                            if (bitcnt == '0) begin
                                spi_miso <= 1'b0;
                            end else begin
                                spi_miso <= shreg[ADC_BITS-1];
                                shreg    <= {shreg[ADC_BITS-2:0], 1'b0};
                            end
                            bitcnt <= bitcnt + CW'(1);
                            if (bitcnt == CW'(ADC_BITS)) begin
                                xfer_done <= 1'b1;
                                state     <= TAIL;
                            end
                        end
                    end
                    TAIL: begin
                        if (fall) begin
                            spi_miso <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mcp3008_spi_responder.sv
module tb_mcp3008_spi_responder;

    localparam int SYNC = 2;
    localparam int HMIN = SYNC + 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       spi_clk = 1'b0;
    logic       spi_mosi = 1'b0;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic       conv_req;
    logic [2:0] conv_channel;
    logic       conv_single;
    logic [9:0] conv_data = 10'd0;
    logic       xfer_done;

    int checks = 0;
    int errors = 0;

    // Monitor counters. Each one counts the clk cycles that its pulse is high.
    int req_hi = 0;
    int done_hi = 0;

    // Expected command state. It persists across frames, as the latched outputs do.
    logic [2:0] exp_ch = 3'd0;
    logic       exp_sgl = 1'b0;
    logic [9:0] src_data = 10'd0;

    mcp3008_spi_responder #(.ADC_BITS(10), .SYNC_STAGES(SYNC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .spi_cs_n     (spi_cs_n),
        .spi_clk      (spi_clk),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .spi_miso_oe  (spi_miso_oe),
        .conv_req     (conv_req),
        .conv_channel (conv_channel),
        .conv_single  (conv_single),
        .conv_data    (conv_data),
        .xfer_done    (xfer_done)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            if (conv_req) req_hi++;
            if (xfer_done) done_hi++;
        end
    end

    // Sample source. The value is valid only in the cycle after conv_req and is junk otherwise.
    initial begin
        forever begin
            @(negedge clk);
            conv_data = conv_req ? src_data : 10'($urandom);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: sim time limit reached, required finish before limit");
        $fatal(1, "watchdog");
    end

    // One SCLK period: MOSI is set during the low phase, MISO is read at the rise, and the task returns with SCLK low.
    task automatic spi_clock(input logic b, input int h, output logic rd);
        spi_mosi = b;
        repeat (h) @(negedge clk);
        rd = spi_miso;
        spi_clk = 1'b1;
        repeat (h) @(negedge clk);
        spi_clk = 1'b0;
    endtask

    // cmd holds ncmd bits, sent MSB first. MOSI is 0 after the command. nclk is the total number of SCLK periods.
    task automatic run_frame(input string name, input logic [31:0] cmd, input int ncmd,
                             input int nclk, input logic [9:0] data, input int h);
        int s;
        int r0;
        int d0;
        logic [63:0] exp_bits;
        logic [63:0] got_bits;
        logic b;
        logic rd;
        s = -1;
        for (int i = 0; i < ncmd; i++) begin
            if (s < 0 && cmd[ncmd-1-i]) s = i;
        end
        // Reference model: the null bit is read at rise s+6, B9..B0 at rises s+7..s+16, and every other rise reads 0.
        exp_bits = '0;
        for (int i = 0; i < nclk; i++) begin
            int k;
            k = i - s - 7;
            if (k >= 0 && k < 10) exp_bits[i] = data[9-k];
        end
        if (nclk > s + 4) begin
            exp_sgl = cmd[ncmd-1-(s+1)];
            exp_ch  = {cmd[ncmd-1-(s+2)], cmd[ncmd-1-(s+3)], cmd[ncmd-1-(s+4)]};
        end
        src_data = data;
        r0 = req_hi;
        d0 = done_hi;
        got_bits = '0;

        spi_cs_n = 1'b0;
        repeat (h) @(negedge clk);
        checks++;
        if (spi_miso_oe !== 1'b1) begin
            errors++;
            $display("FAIL %s oe_selected: got %b want 1", name, spi_miso_oe);
        end
        for (int i = 0; i < nclk; i++) begin
            b = (i < ncmd) ? cmd[ncmd-1-i] : 1'b0;
            spi_clock(b, h, rd);
            got_bits[i] = rd;
        end
        repeat (h) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (SYNC + 2) @(negedge clk);
        checks++;
        if (spi_miso_oe !== 1'b0 || spi_miso !== 1'b0) begin
            errors++;
            $display("FAIL %s deselect: oe=%b miso=%b want 0 0", name, spi_miso_oe, spi_miso);
        end
        repeat (h) @(negedge clk);
        checks++;
        if (got_bits !== exp_bits) begin
            errors++;
            $display("FAIL %s miso_bits: got %h want %h", name, got_bits, exp_bits);
        end
        checks++;
        if ((req_hi - r0) != ((nclk > s + 5) ? 1 : 0)) begin
            errors++;
            $display("FAIL %s conv_req_cycles: got %0d want %0d", name, req_hi - r0, (nclk > s + 5) ? 1 : 0);
        end
        checks++;
        if ((done_hi - d0) != ((nclk > s + 15) ? 1 : 0)) begin
            errors++;
            $display("FAIL %s xfer_done_cycles: got %0d want %0d", name, done_hi - d0, (nclk > s + 15) ? 1 : 0);
        end
        checks++;
        if (conv_channel !== exp_ch || conv_single !== exp_sgl) begin
            errors++;
            $display("FAIL %s command: got ch=%0d sgl=%b want ch=%0d sgl=%b",
                     name, conv_channel, conv_single, exp_ch, exp_sgl);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({spi_miso, spi_miso_oe, conv_req, conv_channel, conv_single, xfer_done} !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: got miso=%b oe=%b req=%b ch=%0d sgl=%b done=%b want all 0",
                     spi_miso, spi_miso_oe, conv_req, conv_channel, conv_single, xfer_done);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (spi_miso_oe !== 1'b0) begin
            errors++;
            $display("FAIL idle_oe: got %b want 0", spi_miso_oe);
        end
    endtask

    task automatic test_basic;
        run_frame("basic_ch3", 32'b11011, 5, 17, 10'h2A5, HMIN);
    endtask

    task automatic test_leading_zeros_diff;
        run_frame("lead0_diff6", 32'b00010110, 8, 20, 10'h3FF, HMIN + 1);
    endtask

    task automatic test_abort;
        run_frame("abort_9", 32'b11101, 5, 9, 10'h2AA, HMIN);
        run_frame("after_abort_ch2", 32'b11010, 5, 17, 10'h001, HMIN);
    endtask

    task automatic test_extra_clocks;
        run_frame("extra_clocks", 32'b11111, 5, 20, 10'h155, HMIN);
    endtask

    task automatic test_reset_mid_shift;
        logic rd;
        src_data = 10'h3FF;
        spi_cs_n = 1'b0;
        repeat (HMIN) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            spi_clock((i < 5) ? 1'(5'b11101 >> (4 - i)) : 1'b0, HMIN, rd);
        end
        repeat (SYNC + 2) @(negedge clk);
        checks++;
        if (spi_miso !== 1'b1 || conv_channel !== 3'd5) begin
            errors++;
            $display("FAIL pre_reset_shift: got miso=%b ch=%0d want 1 5", spi_miso, conv_channel);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({spi_miso, spi_miso_oe, conv_req, conv_channel, conv_single, xfer_done} !== 8'd0) begin
            errors++;
            $display("FAIL async_reset: got miso=%b oe=%b req=%b ch=%0d sgl=%b done=%b want all 0",
                     spi_miso, spi_miso_oe, conv_req, conv_channel, conv_single, xfer_done);
        end
        exp_ch = 3'd0;
        exp_sgl = 1'b0;
        spi_cs_n = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (HMIN) @(negedge clk);
        run_frame("post_reset_ch4", 32'b11100, 5, 17, 10'h0F3, HMIN);
    endtask

    task automatic test_back_to_back;
        run_frame("b2b_ch0", 32'b11000, 5, 17, 10'h21C, HMIN);
        run_frame("b2b_ch7", 32'b11111, 5, 17, 10'h1E3, HMIN);
    endtask

    task automatic test_random;
        for (int n = 0; n < 6; n++) begin
            int lead;
            logic [4:0] c;
            lead = $urandom_range(0, 3);
            c = {1'b1, 1'($urandom), 3'($urandom)};
            run_frame("random", {27'd0, c}, lead + 5, lead + 17 + $urandom_range(0, 2),
                      10'($urandom), $urandom_range(HMIN, HMIN + 3));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_leading_zeros_diff();
        test_abort();
        test_extra_clocks();
        test_reset_mid_shift();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
